ascon_perm_ctrl: RTL and testbench

ASCON_PERM_CTRL -- requirements
Module: ascon_perm_ctrl

---
 rtl/ascon_perm_ctrl.sv | 143 ++++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ascon_perm_ctrl.sv
// Round sequencer for the Ascon permutation: counts round indices for p^a / p^b
// and drives the state-register load enable and input mux select.
module ascon_perm_ctrl #(
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       rounds_sel_i,
    output logic [3:0] round_o,
    output logic       data_sel_o,
    output logic       en_reg_state_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] TOTAL_ROUNDS = CW'(12);
    localparam logic [CW-1:0] LAST_ROUND   = CW'(11);
    localparam logic [CW-1:0] N_A          = CW'(ROUNDS_A);
    localparam logic [CW-1:0] N_B          = CW'(ROUNDS_B);

    if (ROUNDS_A == 0 || ROUNDS_A > 12 || ROUNDS_B == 0 || ROUNDS_B > 12) begin : g_bad_rounds
        $fatal(1, "ascon_perm_ctrl: ROUNDS_A/ROUNDS_B must be in 1..12");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] n_q, n_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] round_q, round_d;
    logic          data_sel_q, data_sel_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // armed_q blocks a start on the first edge after reset release
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= N_A;
            armed_q    <= 1'b0;
            round_q    <= '0;
            data_sel_q <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            armed_q    <= armed_d;
            round_q    <= round_d;
            data_sel_q <= data_sel_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        armed_d    = 1'b1;
        round_d    = '0;
        data_sel_d = 1'b0;
        en_d       = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i && armed_q) begin
                    n_d     = rounds_sel_i ? N_B : N_A;
                    cnt_d   = TOTAL_ROUNDS - n_d;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (n_q == CW'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = ROUND;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ROUND: begin
                if (cnt_q == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they leave the flops aligned with it
        unique case (state_d)
            FIRST: begin
                round_d = cnt_d;
                en_d    = 1'b1;
                busy_d  = 1'b1;
            end
            ROUND: begin
                round_d    = cnt_d;
                data_sel_d = 1'b1;
                en_d       = 1'b1;
                busy_d     = 1'b1;
            end
            DONE: begin
                data_sel_d = 1'b1;
                done_d     = 1'b1;
            end
            default: begin
                round_d = '0;
            end
        endcase
    end

    assign round_o        = round_q;
    assign data_sel_o     = data_sel_q;
    assign en_reg_state_o = en_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl: round sequences, ignored starts, aborts,
// back-to-back runs, and a single-round instance.
module tb_ascon_perm_ctrl;

    logic       clock_i = 1'b0;
    logic       resetb_i;
    logic       start_i, rounds_sel_i;
    logic [3:0] round_o;
    logic       data_sel_o, en_reg_state_o, busy_o, done_o;

    logic       start1_i, sel1_i;
    logic [3:0] round1_o;
    logic       data_sel1_o, en1_o, busy1_o, done1_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock_i = ~clock_i;

    ascon_perm_ctrl dut (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .rounds_sel_i(rounds_sel_i),
        .round_o(round_o), .data_sel_o(data_sel_o), .en_reg_state_o(en_reg_state_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    ascon_perm_ctrl #(.ROUNDS_A(12), .ROUNDS_B(1)) dut1 (
        .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start1_i), .rounds_sel_i(sel1_i),
        .round_o(round1_o), .data_sel_o(data_sel1_o), .en_reg_state_o(en1_o),
        .busy_o(busy1_o), .done_o(done1_o)
    );

    // {round, data_sel, en, busy, done}
    function automatic logic [7:0] pk(input int r, input bit ds, input bit en, input bit b, input bit d);
        return {4'(r), ds, en, b, d};
    endfunction

    function automatic logic [7:0] obs0();
        return {round_o, data_sel_o, en_reg_state_o, busy_o, done_o};
    endfunction

    function automatic logic [7:0] obs1();
        return {round1_o, data_sel1_o, en1_o, busy1_o, done1_o};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed r=%0d ds/en/busy/done=%b required r=%0d ds/en/busy/done=%b",
                   tag, got[7:4], got[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    // Called at the negedge right after the accepting edge; checks the whole run.
    task automatic run_seq(input int n, input string tag, input int pulse_at, input int abort_at);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_r%0d", tag, i), obs0(), pk(12 - n + i, i != 0, 1'b1, 1'b1, 1'b0));
            if (pulse_at >= 0 && i == pulse_at) start_i = 1'b1;
            if (pulse_at >= 0 && i == pulse_at + 1) start_i = 1'b0;
            if (i == abort_at) begin
                resetb_i = 1'b0;
                #1;
                check($sformatf("%s_abort", tag), obs0(), pk(0, 0, 0, 0, 0));
                return;
            end
            @(negedge clock_i);
        end
        check($sformatf("%s_done", tag), obs0(), pk(0, 1, 0, 0, 1));
        @(negedge clock_i);
        check($sformatf("%s_idle", tag), obs0(), pk(0, 0, 0, 0, 0));
    endtask

    initial begin
        resetb_i = 1'b0; start_i = 1'b0; rounds_sel_i = 1'b0; start1_i = 1'b0; sel1_i = 1'b0;
        #1;
        check("reset_async", obs0(), pk(0, 0, 0, 0, 0));
        check("reset_async_n1", obs1(), pk(0, 0, 0, 0, 0));
        @(negedge clock_i);
        @(negedge clock_i);
        check("reset_held", obs0(), pk(0, 0, 0, 0, 0));

        // Release with start already high: the first edge must not start a run
        resetb_i = 1'b1; start_i = 1'b1; rounds_sel_i = 1'b0;
        @(negedge clock_i);
        check("release_edge_ignored", obs0(), pk(0, 0, 0, 0, 0));
        @(negedge clock_i);
        start_i = 1'b0;
        run_seq(12, "p12", -1, -1);

        // p6, rounds_sel flipped after the start edge
        @(negedge clock_i);
        start_i = 1'b1; rounds_sel_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0; rounds_sel_i = 1'b0;
        run_seq(6, "p6", -1, -1);

        // Start pulse during round 5 of a p12 is ignored
        @(negedge clock_i);
        start_i = 1'b1; rounds_sel_i = 1'b0;
        @(negedge clock_i);
        start_i = 1'b0;
        run_seq(12, "p12_pulse", 5, -1);
        @(negedge clock_i);
        check("p12_pulse_no_rerun", obs0(), pk(0, 0, 0, 0, 0));

        // Reset at round 7 aborts; next start runs a full p12
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        run_seq(12, "p12_abort", -1, 7);
        @(negedge clock_i);
        check("abort_held", obs0(), pk(0, 0, 0, 0, 0));
        resetb_i = 1'b1;
        @(negedge clock_i);
        check("abort_released", obs0(), pk(0, 0, 0, 0, 0));
        start_i = 1'b1; rounds_sel_i = 1'b0;
        @(negedge clock_i);
        start_i = 1'b0;
        run_seq(12, "p12_after_abort", -1, -1);

        // Start held high: back-to-back p6 runs with an 8-cycle period
        start_i = 1'b1; rounds_sel_i = 1'b1;
        @(negedge clock_i);
        run_seq(6, "b2b_a", -1, -1);
        @(negedge clock_i);
        run_seq(6, "b2b_b", -1, -1);
        start_i = 1'b0;
        @(negedge clock_i);
        check("b2b_stop", obs0(), pk(0, 0, 0, 0, 0));

        // Single-round instance: FIRST goes straight to DONE
        start1_i = 1'b1; sel1_i = 1'b1;
        @(negedge clock_i);
        start1_i = 1'b0; sel1_i = 1'b0;
        check("n1_first", obs1(), pk(11, 0, 1, 1, 0));
        @(negedge clock_i);
        check("n1_done", obs1(), pk(0, 1, 0, 0, 1));
        @(negedge clock_i);
        check("n1_idle", obs1(), pk(0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion required completion within 100000");
        $fatal(1, "timeout");
    end

endmodule
